// File: rtl/fetch_unit.sv
// Instruction fetch stage: 6-bit PC, 64x32 program memory, one registered instruction per cycle.
// Optional macro FETCH_HALT_EN builds a HALT state entered on opcode 8'hFF.
module fetch_unit #(
   parameter int          AW  = 6,
   parameter int          DW  = 32,
   parameter logic [31:0] NOP = 32'h0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          jmp_sig,
   input  logic          jmp_sig_c,
   input  logic          cond_flag,
   input  logic [AW-1:0] jmp_add,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [DW-1:0] prog_data,
   output logic [DW-1:0] inst,
   output logic          inst_valid,
   output logic [AW-1:0] pc,
   output logic          halted
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rd_data;

   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] inst_q, inst_d;
   logic          inst_valid_q, inst_valid_d;
   logic          take;

   // Program memory is never reset; writes land in any state, reset included.
   always_ff @(posedge clk) begin
      if (prog_we) begin
         mem_q[prog_addr] <= prog_data;
      end
   end

   // Same-cycle write to the read address yields the old word (write lands at the edge).
   assign rd_data = mem_q[pc_q];

   // A bubble decodes to no-op, so any jump request during one is stale.
   assign take = inst_valid_q & (jmp_sig | (jmp_sig_c & cond_flag));

`ifdef FETCH_HALT_EN
   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   logic [0:0] state_q, state_d;
   logic       halted_q, halted_d;

   always_comb begin
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      state_d      = state_q;
      halted_d     = halted_q;
      if (state_q == ST_RUN && !stall) begin
         if (inst_valid_q && inst_q[31:24] == 8'hFF) begin
            inst_d       = NOP[DW-1:0];
            inst_valid_d = 1'b0;
            halted_d     = 1'b1;
            state_d      = ST_HALT;
         end else if (take) begin
            pc_d         = jmp_add;
            inst_d       = NOP[DW-1:0];
            inst_valid_d = 1'b0;
         end else begin
            inst_d       = rd_data;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + {{(AW-1){1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q         <= '0;
         inst_q       <= NOP[DW-1:0];
         inst_valid_q <= 1'b0;
         state_q      <= ST_RUN;
         halted_q     <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         state_q      <= state_d;
         halted_q     <= halted_d;
      end
   end

   assign halted = halted_q;
`else
   always_comb begin
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      if (!stall) begin
         if (take) begin
            pc_d         = jmp_add;
            inst_d       = NOP[DW-1:0];
            inst_valid_d = 1'b0;
         end else begin
            inst_d       = rd_data;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + {{(AW-1){1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q         <= '0;
         inst_q       <= NOP[DW-1:0];
         inst_valid_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   assign halted = 1'b0;
`endif

   assign inst       = inst_q;
   assign inst_valid = inst_valid_q;
   assign pc         = pc_q;

endmodule
